// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: registered field extraction, immediate build and illegal flagging,
// valid/ready on both sides with an optional one-entry skid buffer.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter bit RV32E = 1'b0,
  parameter bit SKID  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm_out,
  output logic            illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            ill;
  } entry_t;

  entry_t      dec;
  entry_t      out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [2:0]  dec_fmt;
  logic [31:0] dec_imm32;
  logic        use_rd, use_rs1, use_rs2, bad;
  logic        accept;

  always_comb begin
    dec_fmt   = FMT_X;
    dec_imm32 = '0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (inst_in[6:0])
      7'b0110011: begin
        dec_fmt = FMT_R;
        use_rd  = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
        use_rd    = 1'b1; use_rs1 = 1'b1;
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
        use_rs1   = 1'b1; use_rs2 = 1'b1;
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                     inst_in[11:8], 1'b0};
        use_rs1   = 1'b1; use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {inst_in[31:12], 12'b0};
        use_rd    = 1'b1;
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                     inst_in[30:21], 1'b0};
        use_rd    = 1'b1;
      end
      default: ;
    endcase

    bad = (inst_in[1:0] != 2'b11) || (dec_fmt == FMT_X);
    if (dec_fmt == FMT_R) begin
      // Only base ops (funct7=0) and SUB/SRA (funct7=0x20) exist in RV32I
      bad = bad || ((inst_in[31:25] != 7'h00) && (inst_in[31:25] != 7'h20))
                || ((inst_in[31:25] == 7'h20) && (inst_in[14:12] != 3'b000)
                                              && (inst_in[14:12] != 3'b101));
    end
    if (RV32E) begin
      bad = bad || (use_rd && inst_in[11]) || (use_rs1 && inst_in[19])
                || (use_rs2 && inst_in[24]);
    end

    dec.pc   = pc_in;
    dec.inst = inst_in;
    dec.ill  = bad;
    dec.fmt  = bad ? FMT_X : dec_fmt;
    dec.imm  = bad ? '0 : XLEN'($signed(dec_imm32));
  end

  assign in_ready = SKID ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID) begin
      if (out_valid_q && !out_ready) begin
        if (accept) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end else if (skid_valid_q) begin
        // in_ready is low while the skid is full, so nothing new can arrive here
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = out_q.pc;
  assign opcode    = out_q.inst[6:0];
  assign rd        = out_q.inst[11:7];
  assign rs1       = out_q.inst[19:15];
  assign rs2       = out_q.inst[24:20];
  assign funct3    = out_q.inst[14:12];
  assign funct7    = out_q.inst[31:25];
  assign fmt       = out_q.fmt;
  assign imm_out   = out_q.imm;
  assign illegal   = out_q.ill;

endmodule
